// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM
// states, ALUOp codes, mux select codes and the per-state control word.
package mips_pkg;

  // Instr[31:26] values the controller understands
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Main FSM states; codes 12-15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  // ALUOp codes consumed by the downstream ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Control word produced for each state; pc_write and branch are later
  // combined with the ALU zero flag into the PC enable
  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       memto_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       instr_done;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // True for every opcode that has an execute path in the FSM
  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the main control FSM and the multicycle datapath.
// master = controller side, slave = datapath side.
interface multicycle_control_if;

  logic [5:0] opcode;
  logic       zero;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, zero,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn,
           instr_done, illegal_op, state
  );

  modport slave (
    output opcode, zero,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn,
           instr_done, illegal_op, state
  );

endinterface

// File: rtl/multicycle_out_decode.sv
// Moore output decoder: maps the current FSM state to its control word.
// Purely combinational; anything not set for a state stays 0.
module multicycle_out_decode
  import mips_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  // Per-state control word, starting from all-zero
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      S_FETCH: begin
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded
        ctrl.alu_src_b = SRCB_IMM_SH;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memto_reg  = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord       = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JEX: begin
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath. Holds the state
// register and next-state logic; the per-state control word comes from
// multicycle_out_decode. Reset masks every output combinationally so no
// write enable can fire in a reset cycle, whatever state is held.
module multicycle_control
  import mips_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  state_t state_reg;
  state_t state_next;
  logic   illegal_next;
  ctrl_t  ctrl_raw;
  ctrl_t  ctrl_out;
  logic   pc_en;
  logic   illegal_out;

  // State register; reset returns to FETCH on the next edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state selection; opcode is consulted in DECODE and MEMADR only
  always_comb begin
    state_next   = S_FETCH;
    illegal_next = 1'b0;
    case (state_reg)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JEX;
          default:      state_next = S_FETCH;
        endcase
        illegal_next = !is_supported(bus.opcode);
      end
      S_MEMADR:  state_next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_next = S_MEMWB;
      S_RTYPEEX: state_next = S_RTYPEWB;
      S_ADDIEX:  state_next = S_ADDIWB;
      default:   state_next = S_FETCH;
    endcase
  end

  multicycle_out_decode u_out_decode (
    .state (state_reg),
    .ctrl  (ctrl_raw)
  );

  // Reset masking and PC enable; zero reaches PCEn without a register
  always_comb begin
    ctrl_out    = CTRL_IDLE;
    pc_en       = 1'b0;
    illegal_out = 1'b0;
    if (!reset) begin
      ctrl_out    = ctrl_raw;
      pc_en       = ctrl_raw.pc_write | (ctrl_raw.branch & bus.zero);
      illegal_out = illegal_next;
    end
  end

  assign bus.IorD       = ctrl_out.iord;
  assign bus.MemWrite   = ctrl_out.mem_write;
  assign bus.IRWrite    = ctrl_out.ir_write;
  assign bus.RegDst     = ctrl_out.reg_dst;
  assign bus.MemtoReg   = ctrl_out.memto_reg;
  assign bus.RegWrite   = ctrl_out.reg_write;
  assign bus.ALUSrcA    = ctrl_out.alu_src_a;
  assign bus.ALUSrcB    = ctrl_out.alu_src_b;
  assign bus.ALUOp      = ctrl_out.alu_op;
  assign bus.PCSrc      = ctrl_out.pc_src;
  assign bus.PCEn       = pc_en;
  assign bus.instr_done = ctrl_out.instr_done;
  assign bus.illegal_op = illegal_out;
  assign bus.state      = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. The reference model is a
// per-opcode list of visited states plus a table of the control word
// each state must show; every cycle is sampled at the falling edge.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Observed control word in the same order as model_ctrl
  logic [15:0] act;
  assign act = {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
                bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSrc,
                bus.PCEn, bus.instr_done};

  typedef int path_t[$];

  // States an instruction walks through, one entry per cycle
  function automatic path_t model_path(input logic [5:0] op);
    path_t p;
    p.push_back(0);
    p.push_back(1);
    case (op)
      6'b100011: begin p.push_back(2); p.push_back(3); p.push_back(4); end
      6'b101011: begin p.push_back(2); p.push_back(5); end
      6'b000000: begin p.push_back(6); p.push_back(7); end
      6'b001000: begin p.push_back(9); p.push_back(10); end
      6'b000100: p.push_back(8);
      6'b000010: p.push_back(11);
      default: ;
    endcase
    return p;
  endfunction

  // Control word required in state s with ALU zero flag z
  function automatic logic [15:0] model_ctrl(input int s, input logic z);
    logic iord, mw, irw, rd, m2r, rw, srca, pcen, done;
    logic [1:0] srcb, aluop, pcsrc;
    {iord, mw, irw, rd, m2r, rw, srca, pcen, done} = '0;
    srcb = 2'b00; aluop = 2'b00; pcsrc = 2'b00;
    case (s)
      0:  begin irw = 1; pcen = 1; srcb = 2'b01; end
      1:  srcb = 2'b11;
      2:  begin srca = 1; srcb = 2'b10; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; done = 1; end
      5:  begin iord = 1; mw = 1; done = 1; end
      6:  begin srca = 1; aluop = 2'b10; end
      7:  begin rd = 1; rw = 1; done = 1; end
      8:  begin srca = 1; aluop = 2'b01; pcsrc = 2'b01; pcen = z; done = 1; end
      9:  begin srca = 1; srcb = 2'b10; end
      10: begin rw = 1; done = 1; end
      11: begin pcsrc = 2'b10; pcen = 1; done = 1; end
      default: ;
    endcase
    return {iord, mw, irw, rd, m2r, rw, srca, srcb, aluop, pcsrc, pcen, done};
  endfunction

  // One full instruction from FETCH; zmode 0/1 fixes zero, 2 randomizes it
  task automatic exec_instr(input logic [5:0] op, input int zmode);
    path_t p = model_path(op);
    logic z;
    logic ill;
    logic [15:0] exp;
    int bad = 0;
    for (int i = 0; i < p.size(); i++) begin
      @(negedge clk);
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      bus.opcode = op;
      bus.zero = z;
      #1;
      exp = model_ctrl(p[i], z);
      ill = (p[i] == 1) && (p.size() == 2);
      checks++;
      if (bus.state !== 4'(p[i])) begin
        errors++; bad++;
        $display("FAIL state op=%b step=%0d got %0d want %0d", op, i, bus.state, p[i]);
      end
      checks++;
      if (act !== exp) begin
        errors++; bad++;
        $display("FAIL ctrl op=%b step=%0d got %b want %b", op, i, act, exp);
      end
      checks++;
      if (bus.illegal_op !== ill) begin
        errors++; bad++;
        $display("FAIL illegal_op op=%b step=%0d got %b want %b", op, i, bus.illegal_op, ill);
      end
    end
    $display("instr op=%b cycles=%0d bad=%0d", op, p.size(), bad);
  endtask

  task automatic test_reset();
    bus.opcode = 6'b100011;
    bus.zero = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (act !== 16'h0000 || bus.illegal_op !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs cycle=%0d got %b/%b want 0", i, act, bus.illegal_op);
      end
      checks++;
      if (bus.state !== 4'd0) begin
        errors++;
        $display("FAIL reset_state cycle=%0d got %0d want 0", i, bus.state);
      end
    end
    @(posedge clk);
    #1 reset = 1'b0;
    $display("reset held 3 cycles, released");
  endtask

  task automatic test_lw();
    exec_instr(6'b100011, 2);
  endtask

  task automatic test_rtype();
    exec_instr(6'b000000, 2);
  endtask

  task automatic test_beq();
    exec_instr(6'b000100, 1);
    exec_instr(6'b000100, 0);
  endtask

  task automatic test_sw_j();
    exec_instr(6'b101011, 2);
    exec_instr(6'b000010, 2);
  endtask

  task automatic test_illegal();
    exec_instr(6'b111111, 2);
    exec_instr(6'b000011, 2);
  endtask

  task automatic test_random();
    logic [5:0] ops [7];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b000000};
    for (int n = 0; n < 40; n++) begin
      ops[6] = 6'($urandom_range(0, 63));
      exec_instr(ops[$urandom_range(0, 6)], 2);
    end
  endtask

  // R-type interrupted by reset in RTYPEEX; RegWrite must never assert
  task automatic test_reset_mid();
    path_t p = model_path(6'b000000);
    logic z;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      z = 1'($urandom_range(0, 1));
      bus.opcode = 6'b000000;
      bus.zero = z;
      #1;
      checks++;
      if (bus.state !== 4'(p[i]) || act !== model_ctrl(p[i], z)) begin
        errors++;
        $display("FAIL mid_pre step=%0d got state %0d ctrl %b want %0d %b",
                 i, bus.state, act, p[i], model_ctrl(p[i], z));
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (act !== 16'h0000 || bus.state !== 4'd6) begin
      errors++;
      $display("FAIL mid_reset_in_ex got state %0d ctrl %b want 6 0", bus.state, act);
    end
    @(negedge clk);
    #1;
    checks++;
    if (act !== 16'h0000 || bus.state !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset_fetch got state %0d ctrl %b want 0 0", bus.state, act);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.state !== 4'd0 || bus.IRWrite !== 1'b1 || bus.RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL mid_release got state %0d IRWrite %b RegWrite %b want 0 1 0",
               bus.state, bus.IRWrite, bus.RegWrite);
    end
    $display("reset mid RTYPEEX, recovered to FETCH");
  endtask

  initial begin
    bus.opcode = 6'b000000;
    bus.zero = 1'b0;
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_sw_j();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath mux select and write enable. It also produces the 2-bit `ALUOp` that feeds the existing ALU control decoder directly downstream. This is the upstream neighbour of ALU control: it turns one opcode into a per-cycle control word.

## Interface
Parameters:
- none; state and opcode encodings are fixed in `mips_pkg`.

Ports:
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `opcode`  in  6  `Instr[31:26]` from the instruction register; valid from the DECODE cycle on.
- `zero`  in  1  ALU zero flag, combinational from the ALU.
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemWrite`  out  1  data memory write enable.
- `IRWrite`  out  1  instruction register load enable.
- `RegDst`  out  1  register write address select: 0 = rt, 1 = rd.
- `MemtoReg`  out  1  register write data select: 0 = ALUOut, 1 = MDR.
- `RegWrite`  out  1  register file write enable.
- `ALUSrcA`  out  1  ALU A input select: 0 = PC, 1 = register A.
- `ALUSrcB`  out  2  ALU B input select: 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- `ALUOp`  out  2  to ALU control: 00 = add, 01 = sub, 10 = use funct.
- `PCSrc`  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `PCEn`  out  1  PC load enable.
- `instr_done`  out  1  one-cycle pulse in the final state of every instruction.
- `illegal_op`  out  1  one-cycle pulse in DECODE when the opcode is unsupported.
- `state`  out  4  current state, for debug and bench visibility.

## Operation
- Moore FSM with a 4-bit state register. Outputs depend only on state, except `PCEn = PCWrite | (Branch & zero)`.
- In every state, any output not listed below is 0.
- State outputs and transitions:
  - FETCH (0): IRWrite=1, PCWrite=1, ALUSrcB=01. Next: DECODE.
  - DECODE (1): ALUSrcB=11, computes the branch target. Next state by opcode:
    - lw 100011 and sw 101011 → MEMADR
    - R-type 000000 → RTYPEEX
    - beq 000100 → BEQEX
    - addi 001000 → ADDIEX
    - j 000010 → JEX
    - any other opcode → FETCH, with illegal_op=1
  - MEMADR (2): ALUSrcA=1, ALUSrcB=10. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD (3): IorD=1. Next: MEMWB.
  - MEMWB (4): MemtoReg=1, RegWrite=1, instr_done=1. Next: FETCH.
  - MEMWR (5): IorD=1, MemWrite=1, instr_done=1. Next: FETCH.
  - RTYPEEX (6): ALUSrcA=1, ALUOp=10. Next: RTYPEWB.
  - RTYPEWB (7): RegDst=1, RegWrite=1, instr_done=1. Next: FETCH.
  - BEQEX (8): ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1, instr_done=1. Next: FETCH.
  - ADDIEX (9): ALUSrcA=1, ALUSrcB=10. Next: ADDIWB.
  - ADDIWB (10): RegWrite=1, instr_done=1. Next: FETCH.
  - JEX (11): PCSrc=10, PCWrite=1, instr_done=1. Next: FETCH.
  - codes 12–15: all outputs 0. Next: FETCH.
- Opcode is sampled in DECODE and again in MEMADR. It is held stable by the instruction register, because IRWrite is asserted only in FETCH.

## Timing
- Reset: while `reset`=1, every output is forced to 0, including PCEn, IRWrite, MemWrite and RegWrite. `state` shows FETCH after the first reset edge.
- The first cycle after `reset` deasserts is FETCH.
- Reset asserted mid-instruction: the next edge returns to FETCH. No write enable is asserted in any cycle where `reset`=1.
- Cycles per instruction:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j: 3
  - illegal opcode: 2, with no instr_done
- `PCEn` in BEQEX follows `zero` combinationally within the same cycle. There is no registered path from `zero` to `PCEn`.
- `ALUOp` is valid in the same cycle as its state. Downstream ALU control is purely combinational.

## Structure
- `mips_pkg` holds:
  - opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - state localparams: S_FETCH … S_JEX
  - ALUOp encodings: ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
- The output decoder, a combinational function of state only, is a natural sub-module named `multicycle_out_decode`. The top level keeps the state register, next-state logic and the PCEn gating.

## Test plan
- Reset held for 3 cycles, then opcode=100011 (lw) → all outputs 0 during reset; state sequence 0,1,2,3,4,0; RegWrite=MemtoReg=1 only in state 4; instr_done pulses once.
- opcode=000000 (R-type) → states 0,1,6,7; ALUOp=10 in state 6; RegDst=1 and RegWrite=1 in state 7.
- opcode=000100 (beq) with zero=1, then a second beq with zero=0 → PCEn=1 in BEQEX for the first and 0 for the second; PCSrc=01 and ALUOp=01 in both.
- opcode=101011 (sw), then 000010 (j) → MemWrite=1 and IorD=1 only in state 5; PCSrc=10 and PCEn=1 in state 11.
- opcode=111111 → illegal_op=1 in DECODE, then FETCH; no write enable other than the FETCH IRWrite/PCEn asserted.
- Reset asserted while in RTYPEEX → RegWrite never asserts; after release, state=0 with IRWrite=1.
